// File: rtl/cpu_pkg.sv
// Shared datapath widths and the result record carried on the common data bus.
// No logic; latency and back-pressure are defined by the modules that import it.
package cpu_pkg;
  localparam int XLEN    = 32;
  localparam int VREG_W  = 5;
  localparam int NUM_CDB = 3;

  typedef struct packed {
    logic [VREG_W-1:0] vregid;
    logic [XLEN-1:0]   val;
  } cdb_entry_t;
endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO: registered push/pop, head visible combinationally, flush empties it.
// No internal back-pressure; the caller must never push a full FIFO without popping it.
module cdb_src_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  cdb_entry_t       i_push_dat,
  input  logic             i_pop,
  output cdb_entry_t       o_head_dat,
  output logic [CNT_W-1:0] o_count
);

  cdb_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-source FIFOs, round-robin grant of up to three results per cycle.
// One-cycle latency to registered buses; src_stall is registered and leaves one slack entry.
module cdb_arbiter
  import cpu_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_en,
  input  logic [VREG_W*NUM_SRC-1:0] src_vregid,
  input  logic [XLEN*NUM_SRC-1:0]   src_val,
  output logic [NUM_SRC-1:0]        src_stall,
  output logic                      writeback1_en,
  output logic [VREG_W-1:0]         writeback1_vregid,
  output logic [XLEN-1:0]           writeback1_val,
  output logic                      writeback2_en,
  output logic [VREG_W-1:0]         writeback2_vregid,
  output logic [XLEN-1:0]           writeback2_val,
  output logic                      writeback3_en,
  output logic [VREG_W-1:0]         writeback3_vregid,
  output logic [XLEN-1:0]           writeback3_val,
  output logic                      overflow_err
);

  localparam int PTR_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  cdb_entry_t         w_in_dat   [NUM_SRC];
  cdb_entry_t         w_head_dat [NUM_SRC];
  cdb_entry_t         w_cand_dat [NUM_SRC];
  logic [CNT_W-1:0]   w_count    [NUM_SRC];
  logic [CNT_W-1:0]   w_cnt_next [NUM_SRC];
  logic [NUM_SRC-1:0] w_cand_vld;
  logic [NUM_SRC-1:0] w_grant;
  logic [NUM_SRC-1:0] w_pop;
  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_drop;
  logic [NUM_SRC-1:0] w_stall_next;
  logic [PTR_W-1:0]   w_rr_next;
  logic [NUM_CDB-1:0] w_bus_vld;
  cdb_entry_t         w_bus_dat  [NUM_CDB];

  logic [PTR_W-1:0]   r_rr_ptr;
  logic [NUM_CDB-1:0] r_wb_en;
  cdb_entry_t         r_wb_dat   [NUM_CDB];
  logic [NUM_SRC-1:0] r_stall;
  logic               r_ovf;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic w_nonempty;
    logic w_full;

    assign w_in_dat[gi]   = {src_vregid[gi*VREG_W +: VREG_W], src_val[gi*XLEN +: XLEN]};
    assign w_nonempty     = (w_count[gi] != '0);
    assign w_full         = (w_count[gi] == CNT_W'(FIFO_DEPTH));
    // An empty FIFO lets the incoming result compete directly (bypass).
    assign w_cand_vld[gi] = w_nonempty || src_en[gi];
    assign w_cand_dat[gi] = w_nonempty ? w_head_dat[gi] : w_in_dat[gi];
    assign w_pop[gi]      = w_grant[gi] && w_nonempty;
    assign w_push[gi]     = src_en[gi] && !(w_grant[gi] && !w_nonempty) && (!w_full || w_pop[gi]);
    assign w_drop[gi]     = src_en[gi] && w_full && !w_pop[gi];
    assign w_cnt_next[gi] = flush ? '0 : w_count[gi] + CNT_W'(w_push[gi]) - CNT_W'(w_pop[gi]);
    assign w_stall_next[gi] = (w_cnt_next[gi] >= CNT_W'(FIFO_DEPTH - 1));

    cdb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_flush    (flush),
      .i_push     (w_push[gi]),
      .i_push_dat (w_in_dat[gi]),
      .i_pop      (w_pop[gi]),
      .o_head_dat (w_head_dat[gi]),
      .o_count    (w_count[gi])
    );
  end

  always_comb begin
    int               idx;
    int               nb;
    logic [PTR_W-1:0] sel;
    logic [1:0]       bsel;
    w_grant   = '0;
    w_bus_vld = '0;
    w_rr_next = r_rr_ptr;
    for (int b = 0; b < NUM_CDB; b++) w_bus_dat[b] = '0;
    idx  = 0;
    nb   = 0;
    sel  = '0;
    bsel = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      sel  = PTR_W'(idx);
      bsel = 2'(nb);
      if (w_cand_vld[sel] && nb < NUM_CDB) begin
        w_grant[sel]    = 1'b1;
        w_bus_vld[bsel] = 1'b1;
        w_bus_dat[bsel] = w_cand_dat[sel];
        w_rr_next       = (idx == NUM_SRC - 1) ? '0 : PTR_W'(idx + 1);
        nb              = nb + 1;
      end
    end
  end

  // Flush suppresses grants, pointer movement and overflow capture for that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr <= '0;
      r_wb_en  <= '0;
      for (int b = 0; b < NUM_CDB; b++) r_wb_dat[b] <= '0;
      r_stall  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_stall <= w_stall_next;
      if (flush) begin
        r_wb_en <= '0;
      end else begin
        r_wb_en  <= w_bus_vld;
        r_rr_ptr <= w_rr_next;
        for (int b = 0; b < NUM_CDB; b++) begin
          if (w_bus_vld[b]) r_wb_dat[b] <= w_bus_dat[b];
        end
        if (|w_drop) r_ovf <= 1'b1;
      end
    end
  end

  assign src_stall         = r_stall;
  assign overflow_err      = r_ovf;
  assign writeback1_en     = r_wb_en[0];
  assign writeback1_vregid = r_wb_dat[0].vregid;
  assign writeback1_val    = r_wb_dat[0].val;
  assign writeback2_en     = r_wb_en[1];
  assign writeback2_vregid = r_wb_dat[1].vregid;
  assign writeback2_val    = r_wb_dat[1].val;
  assign writeback3_en     = r_wb_en[2];
  assign writeback3_vregid = r_wb_dat[2].vregid;
  assign writeback3_val    = r_wb_dat[2].val;

endmodule
